mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one memory port between instruction fetch and the load/store path.
- Arbitrates between the two requesters and sequences each transaction: issue, wait for data, route the response back.
- Catches misaligned and reserved-size accesses before they reach memory, and bounds every access with a timeout.
- Sits between the fetch/decode/load-store logic and the unified memory; allows one outstanding transaction at a time.

## Interface

Parameters:

- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in ISSUE+WAIT before error response; 0 disables timeout
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending

Ports:

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request; held until accepted
- if_req_addr  in  ADDR_W  fetch address (word access)
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  one-cycle fetch response pulse
- if_resp_data  out  DATA_W  fetched word; 0 on error
- if_resp_err  out  1  fetch error (misaligned/timeout)
- d_req_valid  in  1  data request; held until accepted
- d_req_addr  in  ADDR_W  data address
- d_req_r_w  in  1  1 = read, 0 = write
- d_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_req_wdata  in  DATA_W  store data
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  one-cycle data response pulse (reads and writes)
- d_resp_rdata  out  DATA_W  read data; 0 on writes and errors
- d_resp_err  out  1  data error
- mem_req_valid  out  1  memory request
- mem_req_addr / mem_req_r_w / mem_req_size / mem_req_wdata  out  ADDR_W/1/2/DATA_W  registered request fields
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response
- mem_resp_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation

States:

- IDLE
  - Arbitrate and accept at most one request; latch owner, addr, r_w, size, wdata.
  - Fetch requests use r_w = 1, size = 10, wdata = 0.
  - Reads latch wdata = 0.
- Arbitration (combinational in IDLE; ready may depend on valid):
  - Only one valid: grant it.
  - Both valid: grant data unless streak == MAX_DATA_STREAK, then grant fetch.
- streak counter:
  - Cleared on any fetch grant.
  - Cleared on a data grant with if_req_valid = 0.
  - Incremented, saturating at MAX_DATA_STREAK, on a data grant with if_req_valid = 1.
- Accepted request checks:
  - Illegal if size = 11, size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0.
  - Illegal → RESP with err = 1 and no memory access.
  - Legal → ISSUE.
- ISSUE
  - mem_req_valid = 1 with latched fields, stable until mem_req_ready.
  - mem_req_ready → WAIT.
- WAIT
  - mem_resp_valid → latch rdata (writes latch 0) → RESP with err = 0.
- Timeout:
  - tcnt is cleared on entry to ISSUE and increments every cycle in ISSUE/WAIT.
  - When tcnt == TIMEOUT (TIMEOUT != 0) and no handshake occurs that cycle → RESP with err = 1, data 0.
  - mem_req_valid drops the same cycle.
  - A handshake in the same cycle as the timeout wins.
- RESP
  - Owner's resp_valid = 1 for exactly one cycle with data/err → IDLE.
  - The other requester's resp outputs stay 0.
- mem_resp_valid outside WAIT is ignored.
- Memory must not respond to an abandoned (timed-out) request.
- Async reset mid-operation abandons the transaction: no response, mem_req_valid drops immediately.

## Timing

- Reset values:
  - All outputs 0 (all ready, resp, mem_req_* and busy signals).
  - state IDLE, streak 0, tcnt 0.
- Accept at cycle T (valid & ready); busy = 1 from T+1.
- ISSUE at T+1: mem_req_valid = 1.
- If mem_req_ready at T+1 and mem_resp_valid at T+2: resp_valid at T+3, IDLE at T+4.
- Minimum legal transaction is 4 cycles accept-to-accept.
- Illegal access: resp_valid at T+1 with err = 1, IDLE at T+2.
- Memory stall of N cycles in ISSUE or WAIT adds N cycles.
- Timeout response arrives TIMEOUT+1 cycles after entering ISSUE.
- No request is accepted in ISSUE, WAIT or RESP; both readies are 0.

## Test plan

- Fetch 0x100, memory ready at once, returns 0xDEADBEEF at next cycle → if_resp_valid at T+3 with data 0xDEADBEEF, err 0; busy high T+1..T+3.
- Both valid continuously, MAX_DATA_STREAK = 4 → grant sequence D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each F.
- Data write, size 10, addr 0x202 → d_resp_valid at T+1, err 1, mem_req_valid never asserted; half at 0x203 and size 11 at 0x200 give the same result.
- TIMEOUT = 8, memory never responds → d_resp_err = 1, rdata 0 at 9 cycles after ISSUE entry; a late mem_resp_valid in IDLE is ignored.
- mem_req_ready held low 5 cycles → mem_req_* fields stable throughout; response routed correctly afterwards.
- reset pulled low during WAIT → all outputs 0 asynchronously; after release no response; next fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and the
//            load/store path. One outstanding transaction at a time, with
//            alignment/size screening and a per-access timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int TIMEOUT         = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_resp_err,
  // load/store port
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_r_w,
  input  logic [1:0]        d_req_size,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic              d_resp_err,
  // unified memory port
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_r_w,
  output logic [1:0]        mem_req_size,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [TW-1:0] TMO_VAL    = TW'(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = data port owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic              grant_d, grant_f;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic              acc_illegal;
  logic              timeout_hit;

  // Arbitration and screening of the request that would be accepted now
  always_comb begin
    grant_d     = d_req_valid && !(if_req_valid && (streak_q == STREAK_MAX));
    grant_f     = if_req_valid && !grant_d;
    acc_addr    = grant_d ? d_req_addr : if_req_addr;
    acc_size    = grant_d ? d_req_size : 2'b10;
    acc_illegal = (acc_size == 2'b11) ||
                  ((acc_size == 2'b01) && acc_addr[0]) ||
                  ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
    timeout_hit = (TIMEOUT != 0) && (tcnt_q == TMO_VAL);
  end

  // Next-state, transaction bookkeeping and request handshakes
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    streak_d     = streak_q;
    tcnt_d       = tcnt_q;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ready is masked by reset so nothing looks accepted while held in reset
        if_req_ready = reset && grant_f;
        d_req_ready  = reset && grant_d;
        if (grant_f || grant_d) begin
          owner_d = grant_d;
          addr_d  = acc_addr;
          rw_d    = grant_d ? d_req_r_w : 1'b1;
          size_d  = acc_size;
          wdata_d = (grant_d && !d_req_r_w) ? d_req_wdata : '0;
          rdata_d = '0;
          err_d   = acc_illegal;
          tcnt_d  = '0;
          state_d = acc_illegal ? S_RESP : S_ISSUE;
          if (grant_f || !if_req_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        // counter parks at the limit so a late handshake still times out in WAIT
        if (tcnt_q != TMO_VAL) tcnt_d = tcnt_q + TW'(1);
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (tcnt_q != TMO_VAL) tcnt_d = tcnt_q + TW'(1);
        if (mem_resp_valid) begin
          rdata_d = rw_q ? mem_resp_rdata : '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset abandons any transaction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Response routing to the owner only; memory request straight from latched fields
  always_comb begin
    if_resp_valid = (state_q == S_RESP) && !owner_q;
    if_resp_data  = if_resp_valid ? rdata_q : '0;
    if_resp_err   = if_resp_valid && err_q;
    d_resp_valid  = (state_q == S_RESP) && owner_q;
    d_resp_rdata  = d_resp_valid ? rdata_q : '0;
    d_resp_err    = d_resp_valid && err_q;
    mem_req_valid = (state_q == S_ISSUE);
    mem_req_addr  = addr_q;
    mem_req_r_w   = rw_q;
    mem_req_size  = size_q;
    mem_req_wdata = wdata_q;
    busy          = (state_q != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a
//            response scoreboard and a small behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int MS  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req_valid = 1'b0;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_req_ready;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_data;
  logic          if_resp_err;
  logic          d_req_valid = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_req_r_w = 1'b0;
  logic [1:0]    d_req_size = 2'b00;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_rdata;
  logic          d_resp_err;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_r_w;
  logic [1:0]    mem_req_size;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;
  logic          busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_DATA_STREAK(MS)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_r_w(d_req_r_w),
    .d_req_size(d_req_size), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_r_w(mem_req_r_w),
    .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .busy(busy)
  );

  typedef struct {
    bit            dport;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mem_req_cnt = 0;
  int   resp_cnt = 0;

  // memory model controls and the request the stimulus expects it to see
  bit            mem_mute = 0;
  bit            mem_noresp = 0;
  int            mem_stall = 0;
  logic [AW-1:0] x_addr = '0;
  bit            x_rw = 0;
  logic [1:0]    x_size = 2'b00;
  logic [DW-1:0] x_wdata = '0;
  bit            pend = 0;
  logic [DW-1:0] pend_data = '0;
  bit            seen = 0;
  logic [66:0]   s_fields = '0;

  bit exp_grant[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], 16'h5A5A} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // behavioural memory: optional stall, then accept and answer one cycle later
  always @(negedge clock) begin
    if (mem_req_valid) mem_req_cnt++;
    if (!mem_mute) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend_data;
        pend = 0;
      end else if (mem_req_valid) begin
        if (!seen) begin
          seen = 1;
          s_fields = {mem_req_addr, mem_req_r_w, mem_req_size, mem_req_wdata};
          chk("mem_req_fields", s_fields, {x_addr, x_rw, x_size, x_wdata});
        end else begin
          chk("mem_req_stable", {mem_req_addr, mem_req_r_w, mem_req_size, mem_req_wdata}, s_fields);
        end
        if (mem_stall > 0) begin
          mem_stall--;
        end else begin
          mem_req_ready = 1'b1;
          seen = 0;
          if (!mem_noresp) begin
            pend = 1;
            pend_data = mem_req_r_w ? mem_fn(mem_req_addr) : 32'hBAD0_0000;
          end
        end
      end
    end
  end

  // scoreboard: every response pulse pops and compares one expectation
  always @(negedge clock) begin
    if (reset && (if_resp_valid || d_resp_valid)) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {if_resp_valid, d_resp_valid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("resp_owner", {d_resp_valid, if_resp_valid}, e.dport ? 2'b10 : 2'b01);
        if (e.dport) begin
          chk("d_resp", {d_resp_rdata, d_resp_err}, {e.data, e.err});
          chk("if_quiet", {if_resp_data, if_resp_err}, '0);
        end else begin
          chk("if_resp", {if_resp_data, if_resp_err}, {e.data, e.err});
          chk("d_quiet", {d_resp_rdata, d_resp_err}, '0);
        end
      end
    end
  end

  task automatic push_exp(input bit dp, input bit rw, input logic [1:0] sz,
                          input logic [AW-1:0] a, input bit tmo);
    exp_t n;
    bit ill;
    ill = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
    n.dport = dp;
    n.err   = ill || tmo;
    n.data  = (ill || tmo || !rw) ? '0 : mem_fn(a);
    exp_q.push_back(n);
  endtask

  task automatic send(input bit dp, input bit rw, input logic [1:0] sz,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit tmo);
    bit ok;
    @(negedge clock);
    x_addr = a; x_rw = rw; x_size = sz; x_wdata = rw ? '0 : wd;
    if (dp) begin
      d_req_valid = 1; d_req_addr = a; d_req_r_w = rw; d_req_size = sz; d_req_wdata = wd;
    end else begin
      if_req_valid = 1; if_req_addr = a;
    end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (dp ? d_req_ready : if_req_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("accept", ok, 1'b1);
    @(posedge clock);
    #1;
    if_req_valid = 0;
    d_req_valid  = 0;
    push_exp(dp, rw, sz, a, tmo);
  endtask

  task automatic wait_resp(input bit dp, input int lat, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cnt++;
      if (dp ? d_resp_valid : if_resp_valid) break;
    end
    chk(tag, cnt, lat);
    @(negedge clock);
    chk("idle_after_resp", {busy, mem_req_valid}, 2'b00);
  endtask

  initial begin
    int snap;
    bit ok;
    bit gd;

    // reset state
    #3;
    chk("reset_outputs", |{if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
                           d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
                           mem_req_valid, mem_req_addr, mem_req_r_w, mem_req_size,
                           mem_req_wdata, busy}, 1'b0);
    repeat (2) @(posedge clock);
    #2 reset = 1;

    // basic fetch with cycle-by-cycle timing
    send(0, 1, 2'b10, 32'h100, '0, 0);
    @(negedge clock);
    chk("t1_issue", {busy, mem_req_valid}, 2'b11);
    @(negedge clock);
    chk("t2_wait", {busy, mem_req_valid}, 2'b10);
    @(negedge clock);
    chk("t3_resp", {busy, if_resp_valid, d_resp_valid}, 3'b110);
    @(negedge clock);
    chk("t4_idle", busy, 1'b0);

    // both requesters valid: data streak of MAX then a fetch
    @(negedge clock);
    if_req_valid = 1; if_req_addr = 32'h400;
    d_req_valid = 1; d_req_addr = 32'h800; d_req_r_w = 1; d_req_size = 2'b10;
    for (int g = 0; g < 10; g++) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (if_req_ready || d_req_ready) begin ok = 1; break; end
        @(negedge clock);
      end
      chk("streak_accept", ok, 1'b1);
      chk("ready_onehot", if_req_ready && d_req_ready, 1'b0);
      gd = d_req_ready;
      chk("streak_grant", gd, exp_grant[g]);
      x_addr = gd ? d_req_addr : if_req_addr; x_rw = 1; x_size = 2'b10; x_wdata = '0;
      push_exp(gd, 1, 2'b10, x_addr, 0);
      @(posedge clock);
      #1;
      if (gd) d_req_addr = d_req_addr + 4;
      else    if_req_addr = if_req_addr + 4;
      if (g == 9) begin if_req_valid = 0; d_req_valid = 0; end
      @(negedge clock);
    end
    for (int i = 0; i < 20 && (busy || exp_q.size() != 0); i++) @(negedge clock);
    chk("streak_drain", exp_q.size(), 0);

    // illegal accesses: immediate error, memory untouched
    snap = mem_req_cnt;
    send(1, 0, 2'b10, 32'h202, 32'h1111_2222, 0);
    wait_resp(1, 1, "ill_word_lat");
    send(1, 0, 2'b01, 32'h203, 32'h3333_4444, 0);
    wait_resp(1, 1, "ill_half_lat");
    send(1, 1, 2'b11, 32'h200, '0, 0);
    wait_resp(1, 1, "ill_size_lat");
    send(0, 1, 2'b10, 32'h102, '0, 0);
    wait_resp(0, 1, "ill_fetch_lat");
    chk("ill_no_mem", mem_req_cnt - snap, 0);

    // legal data accesses
    send(1, 1, 2'b00, 32'h301, '0, 0);
    wait_resp(1, 3, "rd_byte_lat");
    send(1, 0, 2'b10, 32'h304, 32'hCAFE_F00D, 0);
    wait_resp(1, 3, "wr_word_lat");
    send(1, 1, 2'b01, 32'h306, '0, 0);
    wait_resp(1, 3, "rd_half_lat");

    // timeout in WAIT, then a stray memory response while idle
    mem_noresp = 1;
    send(1, 1, 2'b10, 32'h500, '0, 1);
    wait_resp(1, TMO + 2, "tmo_wait_lat");
    @(posedge clock);
    #1;
    mem_mute = 1; mem_noresp = 0; mem_req_ready = 0; mem_resp_valid = 0;
    snap = resp_cnt;
    @(negedge clock);
    mem_resp_valid = 1; mem_resp_rdata = 32'h1111_1111;
    @(negedge clock);
    mem_resp_valid = 0;
    repeat (2) @(negedge clock);
    chk("late_resp_ignored", {resp_cnt - snap, busy}, 0);

    // timeout in ISSUE (memory never ready)
    send(0, 1, 2'b10, 32'h600, '0, 1);
    wait_resp(0, TMO + 2, "tmo_issue_lat");
    @(posedge clock);
    #1 mem_mute = 0;

    // memory stalls the request for five cycles
    mem_stall = 5;
    send(1, 0, 2'b10, 32'h700, 32'h1234_5678, 0);
    wait_resp(1, 8, "stall_wr_lat");
    mem_stall = 5;
    send(0, 1, 2'b10, 32'h104, '0, 0);
    wait_resp(0, 8, "stall_fetch_lat");

    // asynchronous reset while waiting for memory
    mem_noresp = 1;
    send(1, 1, 2'b10, 32'h800, '0, 0);
    repeat (2) @(negedge clock);
    chk("pre_reset_busy", busy, 1'b1);
    #2;
    reset = 0;
    if_req_valid = 1; if_req_addr = 32'h100;
    #1;
    chk("async_reset_outputs", |{if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
                                 d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
                                 mem_req_valid, mem_req_addr, mem_req_r_w, mem_req_size,
                                 mem_req_wdata, busy}, 1'b0);
    exp_q.delete();
    @(negedge clock);
    if_req_valid = 0;
    @(posedge clock);
    #2;
    reset = 1;
    mem_noresp = 0;
    snap = resp_cnt;
    repeat (5) @(negedge clock);
    chk("no_resp_after_reset", {resp_cnt - snap, busy}, 0);
    send(0, 1, 2'b10, 32'h100, '0, 0);
    wait_resp(0, 3, "fetch_after_reset");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
